// File: rtl/mem_responder_if.sv
// CPU/loader bus into the main-memory responder.
// master = CPU and loader side, slave = responder side.
interface mem_responder_if #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  i_req;
  logic                  i_we;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DWIDTH-1:0]     i_data;
  logic [DWIDTH-1:0]     o_data;
  logic                  o_ready;
  logic                  o_busy;
  logic                  i_load_en;
  logic [ADDR_WIDTH-1:0] i_load_addr;
  logic [DWIDTH-1:0]     i_load_data;
  logic                  o_load_ack;

  modport master (
    output i_req, i_we, i_addr, i_data, i_load_en, i_load_addr, i_load_data,
    input  o_data, o_ready, o_busy, o_load_ack
  );

  modport slave (
    input  i_req, i_we, i_addr, i_data, i_load_en, i_load_addr, i_load_data,
    output o_data, o_ready, o_busy, o_load_ack
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed main memory serving one CPU access at a time with programmable
// wait states, plus a load port that writes only while the CPU bus is idle.
//
// state | meaning
// IDLE  | waiting for i_req; load-port writes allowed when i_req=0
// WAIT  | wait states, counter runs 1..WAIT_CYCLES
// RESP  | o_ready pulse; access committed on entry
module mem_responder #(
  parameter int DWIDTH      = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset_n,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0]     lat_data;
  logic [DWIDTH-1:0]     o_data_q;
  logic                  o_ready_q;
  logic                  o_busy_q;
  logic                  o_load_ack_q;

  logic [DWIDTH-1:0]     mem [2**ADDR_WIDTH];

  logic                  accept;
  logic                  load_ok;
  logic                  commit;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DWIDTH-1:0]     c_data;

  // With zero wait states the commit lands on the accept edge, so it must use
  // the live request rather than the latched copy.
  always_comb begin
    accept  = 1'b0;
    load_ok = 1'b0;
    commit  = 1'b0;
    c_we    = lat_we;
    c_addr  = lat_addr;
    c_data  = lat_data;
    if (state == IDLE) begin
      accept  = bus.i_req;
      load_ok = bus.i_load_en && !bus.i_req;
      c_we    = bus.i_we;
      c_addr  = bus.i_addr;
      c_data  = bus.i_data;
      if (WAIT_CYCLES == 0) commit = bus.i_req;
    end else if (state == WAIT) begin
      commit = (cnt == WAIT_LAST);
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (commit && c_we) begin
      mem[c_addr] <= c_data;
    end else if (load_ok) begin
      mem[bus.i_load_addr] <= bus.i_load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_data     <= '0;
      o_data_q     <= '0;
      o_ready_q    <= 1'b0;
      o_busy_q     <= 1'b0;
      o_load_ack_q <= 1'b0;
    end else begin
      o_ready_q    <= commit;
      o_load_ack_q <= load_ok;
      if (commit && !c_we) o_data_q <= mem[c_addr];
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we   <= bus.i_we;
            lat_addr <= bus.i_addr;
            lat_data <= bus.i_data;
            o_busy_q <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) state <= RESP;
          else                  cnt   <= cnt + 4'd1;
        end
        RESP: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          o_busy_q <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          o_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.o_ready    = o_ready_q;
  assign bus.o_busy     = o_busy_q;
  assign bus.o_load_ack = o_load_ack_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of accesses plus hand-written sequences for
// latency, mid-access input changes, load/CPU collision and reset during WAIT.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [15:0] exp_q[$];

  mem_responder_if #(.DWIDTH(16), .ADDR_WIDTH(12)) bus ();

  mem_responder #(.DWIDTH(16), .ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          load;
    bit          we;
    logic [11:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each o_ready pops the o_data value expected in that RESP cycle.
  always @(negedge clk) begin
    if (reset_n && bus.o_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(bus.o_ready), 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("resp_data", 32'(bus.o_data), 32'(e));
        check("busy_in_resp", 32'(bus.o_busy), 32'd1);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_access(input bit we, input logic [11:0] addr, input logic [15:0] data,
                           input logic [15:0] exp);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.i_req  = 1'b1;
    bus.i_we   = we;
    bus.i_addr = addr;
    bus.i_data = data;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    drain();
  endtask

  task automatic do_load(input logic [11:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    bus.i_load_en   = 1'b1;
    bus.i_load_addr = addr;
    bus.i_load_data = data;
    @(posedge clk); #1;
    bus.i_load_en = 1'b0;
    @(negedge clk);
    check("load_ack", 32'(bus.o_load_ack), 32'd1);
    @(negedge clk);
    check("load_ack_once", 32'(bus.o_load_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_at, rdy_n, busy_n, ack_n;

    tbl[0]  = '{0, 1, 12'h0FF, 16'h1234, 16'hBEEF};
    tbl[1]  = '{0, 0, 12'h0FF, 16'h0000, 16'h1234};
    tbl[2]  = '{0, 0, 12'h100, 16'h0000, 16'h7777};
    tbl[3]  = '{1, 0, 12'h020, 16'h0F0F, 16'h0000};
    tbl[4]  = '{0, 0, 12'h020, 16'h0000, 16'h0F0F};
    tbl[5]  = '{0, 1, 12'h020, 16'hCAFE, 16'h0F0F};
    tbl[6]  = '{0, 0, 12'h020, 16'h0000, 16'hCAFE};
    tbl[7]  = '{0, 1, 12'h000, 16'hFFFF, 16'hCAFE};
    tbl[8]  = '{0, 0, 12'h000, 16'h0000, 16'hFFFF};
    tbl[9]  = '{0, 1, 12'hFFF, 16'h0001, 16'hFFFF};
    tbl[10] = '{0, 0, 12'hFFF, 16'h0000, 16'h0001};
    tbl[11] = '{0, 0, 12'h005, 16'h0000, 16'hBEEF};

    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_data = '0;
    bus.i_load_en = 1'b0; bus.i_load_addr = '0; bus.i_load_data = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.o_ready), 32'd0);
    check("idle_busy", 32'(bus.o_busy), 32'd0);
    check("idle_data", 32'(bus.o_data), 32'h0000);
    check("idle_ack", 32'(bus.o_load_ack), 32'd0);

    do_load(12'h005, 16'hBEEF);
    do_load(12'h100, 16'h7777);
    do_load(12'h010, 16'h0101);
    do_load(12'h030, 16'h0303);

    // Latency: req driven after edge E0, accepted at E1, RESP after E3
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 12'h005;
    rdy_at = -1; rdy_n = 0; busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        rdy_n++;
        if (rdy_at < 0) rdy_at = i;
      end
      if (bus.o_busy) busy_n++;
      if (i == 1) bus.i_req = 1'b0;
    end
    check("ready_latency", 32'(rdy_at), 32'd3);
    check("ready_pulses", 32'(rdy_n), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'd3);
    drain();

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].load) do_load(tbl[i].addr, tbl[i].data);
      else             do_access(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp);
    end

    // Inputs changed during WAIT are ignored
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 12'h0FF; bus.i_data = 16'hAAAA;
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.i_addr = 12'h100; bus.i_data = 16'h5A5A;
    @(posedge clk); #1;
    bus.i_we = 1'b0; bus.i_addr = 12'h101; bus.i_data = 16'hA5A5;
    drain();
    do_access(1'b0, 12'h0FF, 16'h0000, 16'hAAAA);
    do_access(1'b0, 12'h100, 16'h0000, 16'h7777);

    // CPU request and load strobe together: CPU wins, load dropped
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 12'h005;
    bus.i_load_en = 1'b1; bus.i_load_addr = 12'h030; bus.i_load_data = 16'h3333;
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.i_load_en = 1'b0;
    ack_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_load_ack) ack_n++;
    end
    check("collision_no_ack", 32'(ack_n), 32'd0);
    drain();
    do_access(1'b0, 12'h030, 16'h0000, 16'h0303);
    do_load(12'h030, 16'h3333);
    do_access(1'b0, 12'h030, 16'h0000, 16'h3333);

    // Reset during WAIT of a write discards it
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 12'h010; bus.i_data = 16'h5555;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    @(negedge clk);
    check("busy_in_wait", 32'(bus.o_busy), 32'd1);
    reset_n = 1'b0;
    rdy_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.o_ready) rdy_n++;
    end
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_ready) rdy_n++;
    end
    check("rst_no_ready", 32'(rdy_n), 32'd0);
    do_access(1'b0, 12'h010, 16'h0000, 16'h0101);
    do_access(1'b0, 12'h005, 16'h0000, 16'hBEEF);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
